// File: rtl/cpu_pkg.sv
// Types shared between execute_stage and mem_wb_stage: datapath width, stage FSM
// encoding and the execute-to-memory bundle.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic            flag;
    logic            reg_wr_en;
    logic            mem_rd;
    logic            mem_wr;
  } ex_bundle_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts MEM cycles without a memory ack; o_tc flags the last cycle the stage
// will wait before aborting the access.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(TIMEOUT - 1));
  assign o_tc = w_tc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: takes the execute bundle, runs a req/ack
// data-memory transaction for loads/stores and strobes the register file.
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_reg_wr_en,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_flag,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            rf_wr_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            flag_wb,
  output logic            mem_err
);

  import cpu_pkg::*;

  state_e          r_state;
  ex_bundle_t      r_op;
  logic            r_req;
  logic            r_rf_wr_en;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_flag_wb;
  logic            r_mem_err;
  logic            w_tc;
  logic            w_ctr_clr;
  logic            w_ctr_en;
  logic            w_is_mem;
  logic            w_ex_wr;
  logic            w_op_wr;

  assign w_is_mem  = ex_mem_rd | ex_mem_wr;
  assign w_ex_wr   = ex_reg_wr_en & (ex_rd != 5'd0);
  assign w_op_wr   = r_op.reg_wr_en & (r_op.rd != 5'd0);
  assign w_ctr_clr = (r_state != MEM);
  assign w_ctr_en  = (r_state == MEM) & ~dmem_ack;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_ctr_clr),
    .i_en  (w_ctr_en),
    .o_tc  (w_tc)
  );

  assign ex_ready   = (r_state == IDLE);
  assign dmem_req   = r_req;
  assign dmem_we    = r_req & r_op.mem_wr;
  assign dmem_addr  = r_op.result;
  assign dmem_wdata = r_op.store_data;
  assign rf_wr_en   = r_rf_wr_en;
  assign rf_rd      = r_rf_rd;
  assign rf_wdata   = r_rf_wdata;
  assign flag_wb    = r_flag_wb;
  assign mem_err    = r_mem_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_req      <= 1'b0;
      r_rf_wr_en <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= '0;
      r_flag_wb  <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      r_rf_wr_en <= 1'b0;
      r_mem_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ex_valid) begin
            if (w_is_mem) begin
              if (ex_result[1:0] != 2'b00) begin
                r_mem_err <= 1'b1;
              end else begin
                r_op  <= '{rd: ex_rd, result: ex_result, store_data: ex_store_data,
                           flag: ex_flag, reg_wr_en: ex_reg_wr_en,
                           mem_rd: ex_mem_rd, mem_wr: ex_mem_wr};
                r_req   <= 1'b1;
                r_state <= MEM;
              end
            end else begin
              // rf_rd/rf_wdata only move when a write is actually strobed
              r_rf_wr_en <= w_ex_wr;
              if (w_ex_wr) begin
                r_rf_rd    <= ex_rd;
                r_rf_wdata <= ex_result;
              end
              r_flag_wb <= ex_flag;
              r_state   <= WB;
            end
          end
        end
        MEM: begin
          // an ack arriving on the terminal count still completes the access
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (r_op.mem_rd) begin
              r_rf_wr_en <= w_op_wr;
              if (w_op_wr) begin
                r_rf_rd    <= r_op.rd;
                r_rf_wdata <= dmem_rdata;
              end
              r_flag_wb <= r_op.flag;
              r_state   <= WB;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_tc) begin
            r_req     <= 1'b0;
            r_mem_err <= 1'b1;
            r_state   <= IDLE;
          end
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus randomized ops checked
// against a transaction-level model of the stage's rules.
module tb_mem_wb_stage;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_ready, ex_reg_wr_en, ex_flag, ex_mem_rd, ex_mem_wr;
  logic [4:0]      ex_rd, rf_rd;
  logic [XLEN-1:0] ex_result, ex_store_data, dmem_addr, dmem_wdata, dmem_rdata, rf_wdata;
  logic            dmem_req, dmem_we, dmem_ack, rf_wr_en, flag_wb, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  // last values actually written to the register-file port
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wd;
  logic            m_flag;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg_wr_en(ex_reg_wr_en),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_flag(ex_flag), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .flag_wb(flag_wb), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_reg_wr_en = 0; ex_flag = 0;
    ex_rd = '0; ex_result = '0; ex_store_data = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic drive(input logic rd_op, input logic wr_op, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic we, input logic flg);
    ex_valid = 1; ex_mem_rd = rd_op; ex_mem_wr = wr_op; ex_rd = rd;
    ex_result = res; ex_store_data = sd; ex_reg_wr_en = we; ex_flag = flg;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1'b1, 1'b0, 5'd3, 32'h100, 32'h1, 1'b1, 1'b1);
    tick();
    tick();
    n_tests++;
    if (ex_ready !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== '0 ||
        dmem_wdata !== '0 || rf_wr_en !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== '0 ||
        flag_wb !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b req=%b we=%b addr=%h wd=%h rfwe=%b rd=%0d rfwd=%h flag=%b err=%b, required ready=1 and all else 0",
               ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, rf_wr_en, rf_rd, rf_wdata, flag_wb, mem_err);
    end
    idle_inputs();
    rst_n = 1;
    tick();
    m_rd = 5'd0; m_wd = '0; m_flag = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b0, 1'b0, 5'b10010, 32'hAAAAAAAA, 32'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    n_tests++;
    if (rf_wr_en !== 1'b1 || rf_rd !== 5'd18 || rf_wdata !== 32'hAAAAAAAA || flag_wb !== 1'b1 || ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_wb: we=%b rd=%0d wd=%h flag=%b ready=%b, required 1 18 aaaaaaaa 1 0",
               rf_wr_en, rf_rd, rf_wdata, flag_wb, ex_ready);
    end
    tick();
    n_tests++;
    if (rf_wr_en !== 1'b0 || ex_ready !== 1'b1 || rf_rd !== 5'd18 || rf_wdata !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL alu_after: we=%b ready=%b rd=%0d wd=%h, required 0 1 18 aaaaaaaa",
               rf_wr_en, ex_ready, rf_rd, rf_wdata);
    end
    m_rd = 5'd18; m_wd = 32'hAAAAAAAA; m_flag = 1'b1;
  endtask

  task automatic test_x0();
    drive(1'b0, 1'b0, 5'd0, 32'h12345678, 32'h0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    n_tests++;
    if (rf_wr_en !== 1'b0 || rf_rd !== m_rd || rf_wdata !== m_wd || flag_wb !== 1'b0 || ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_suppress: we=%b rd=%0d wd=%h flag=%b ready=%b, required 0 %0d %h 0 0",
               rf_wr_en, rf_rd, rf_wdata, flag_wb, ex_ready, m_rd, m_wd);
    end
    m_flag = 1'b0;
    tick();
  endtask

  task automatic test_load();
    int c;
    drive(1'b1, 1'b0, 5'd7, 32'h00000010, 32'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    c = 0;
    while (dmem_req === 1'b1 && c < TO + 2) begin
      c++;
      n_tests++;
      if (dmem_we !== 1'b0 || dmem_addr !== 32'h10 || ex_ready !== 1'b0 || rf_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL load_hold c%0d: we=%b addr=%h ready=%b rfwe=%b, required 0 00000010 0 0",
                 c, dmem_we, dmem_addr, ex_ready, rf_wr_en);
      end
      if (c == 3) begin dmem_ack = 1; dmem_rdata = 32'h87654321; end
      tick();
      dmem_ack = 0;
    end
    n_tests++;
    if (c !== 3 || rf_wr_en !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h87654321 || ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wb: reqcycles=%0d we=%b rd=%0d wd=%h ready=%b, required 3 1 7 87654321 0",
               c, rf_wr_en, rf_rd, rf_wdata, ex_ready);
    end
    m_rd = 5'd7; m_wd = 32'h87654321; m_flag = 1'b1;
    tick();
    n_tests++;
    if (ex_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done: ready=%b we=%b, required 1 0", ex_ready, rf_wr_en);
    end
  endtask

  task automatic test_store();
    int c;
    drive(1'b0, 1'b1, 5'd9, 32'h00000020, 32'h55555555, 1'b1, 1'b0);
    tick();
    idle_inputs();
    c = 0;
    while (dmem_req === 1'b1 && c < TO + 2) begin
      c++;
      n_tests++;
      if (dmem_we !== 1'b1 || dmem_addr !== 32'h20 || dmem_wdata !== 32'h55555555 || rf_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL store_hold c%0d: we=%b addr=%h wd=%h rfwe=%b, required 1 00000020 55555555 0",
                 c, dmem_we, dmem_addr, dmem_wdata, rf_wr_en);
      end
      if (c == 2) dmem_ack = 1;
      tick();
      dmem_ack = 0;
    end
    n_tests++;
    if (c !== 2 || rf_wr_en !== 1'b0 || ex_ready !== 1'b1 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_done: reqcycles=%0d rfwe=%b ready=%b err=%b, required 2 0 1 0",
               c, rf_wr_en, ex_ready, mem_err);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 5'd4, 32'h00000013, 32'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    n_tests++;
    if (mem_err !== 1'b1 || dmem_req !== 1'b0 || rf_wr_en !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned: err=%b req=%b rfwe=%b ready=%b, required 1 0 0 1",
               mem_err, dmem_req, rf_wr_en, ex_ready);
    end
    tick();
    n_tests++;
    if (mem_err !== 1'b0 || dmem_req !== 1'b0 || rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_after: err=%b req=%b rfwe=%b, required 0 0 0", mem_err, dmem_req, rf_wr_en);
    end
  endtask

  task automatic test_timeout();
    int c;
    drive(1'b1, 1'b0, 5'd5, 32'h00000040, 32'h0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    c = 0;
    while (dmem_req === 1'b1 && c < TO + 4) begin
      c++;
      tick();
    end
    n_tests++;
    if (c !== TO || mem_err !== 1'b1 || ex_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: reqcycles=%0d err=%b ready=%b rfwe=%b, required %0d 1 1 0",
               c, mem_err, ex_ready, rf_wr_en, TO);
    end
    tick();
    n_tests++;
    if (mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: err=%b, required 0", mem_err);
    end
  endtask

  task automatic test_reset_mid_mem();
    drive(1'b0, 1'b1, 5'd6, 32'h00000080, 32'hDEADBEEF, 1'b1, 1'b1);
    tick();
    idle_inputs();
    tick();
    rst_n = 0;
    tick();
    n_tests++;
    if (ex_ready !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== '0 ||
        dmem_wdata !== '0 || rf_wr_en !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== '0 ||
        flag_wb !== 1'b0 || mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mem: ready=%b req=%b we=%b addr=%h wd=%h rfwe=%b rd=%0d rfwd=%h flag=%b err=%b, required ready=1 and all else 0",
               ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, rf_wr_en, rf_rd, rf_wdata, flag_wb, mem_err);
    end
    rst_n = 1;
    tick();
    m_rd = 5'd0; m_wd = '0; m_flag = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0]  rd;
    logic [31:0] res, sd, rdata;
    logic        we_en, flg, wr;
    int          kind, w, c, exp_c;
    bit          is_st, mis, timed_out;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rd = 5'd0;
      we_en = 1'($urandom); flg = 1'($urandom);
      res = $urandom; sd = $urandom; rdata = $urandom;
      is_st = (kind == 2);
      if (kind != 0) res[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mis = (kind != 0) && (res[1:0] != 2'b00);
      w = (i < 2) ? TO - 1 : $urandom_range(0, TO + 1);
      wr = we_en && (rd != 5'd0);
      n_tests++;
      if (ex_ready !== 1'b1 || rf_wr_en !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_idle: ready=%b rfwe=%b req=%b, required 1 0 0", i, ex_ready, rf_wr_en, dmem_req);
      end
      drive(kind == 1, kind == 2, rd, res, sd, we_en, flg);
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      tick();
      idle_inputs();
      if (kind == 0) begin
        if (wr) begin m_rd = rd; m_wd = res; end
        m_flag = flg;
        n_tests++;
        if (rf_wr_en !== wr || ex_ready !== 1'b0 || flag_wb !== m_flag || rf_rd !== m_rd || rf_wdata !== m_wd) begin
          n_fail++;
          $display("FAIL rnd%0d_alu: we=%b ready=%b flag=%b rd=%0d wd=%h, required %b 0 %b %0d %h",
                   i, rf_wr_en, ex_ready, flag_wb, rf_rd, rf_wdata, wr, m_flag, m_rd, m_wd);
        end
        tick();
      end else if (mis) begin
        n_tests++;
        if (mem_err !== 1'b1 || dmem_req !== 1'b0 || ex_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd%0d_mis: err=%b req=%b ready=%b rfwe=%b, required 1 0 1 0",
                   i, mem_err, dmem_req, ex_ready, rf_wr_en);
        end
      end else begin
        c = 0;
        while (dmem_req === 1'b1 && c < TO + 2) begin
          c++;
          n_tests++;
          if (dmem_we !== is_st || dmem_addr !== res || dmem_wdata !== sd || ex_ready !== 1'b0 ||
              rf_wr_en !== 1'b0 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_mem c%0d: we=%b addr=%h wd=%h ready=%b rfwe=%b err=%b, required %b %h %h 0 0 0",
                     i, c, dmem_we, dmem_addr, dmem_wdata, ex_ready, rf_wr_en, mem_err, is_st, res, sd);
          end
          if (c == w + 1) begin dmem_ack = 1; dmem_rdata = rdata; end
          tick();
          dmem_ack = 0;
        end
        timed_out = (w + 1 > TO);
        exp_c = timed_out ? TO : w + 1;
        n_tests++;
        if (c !== exp_c) begin
          n_fail++;
          $display("FAIL rnd%0d_reqlen: %0d cycles, required %0d", i, c, exp_c);
        end
        if (timed_out) begin
          n_tests++;
          if (mem_err !== 1'b1 || ex_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_timeout: err=%b ready=%b rfwe=%b, required 1 1 0", i, mem_err, ex_ready, rf_wr_en);
          end
        end else if (!is_st) begin
          if (wr) begin m_rd = rd; m_wd = rdata; end
          m_flag = flg;
          n_tests++;
          if (rf_wr_en !== wr || ex_ready !== 1'b0 || mem_err !== 1'b0 || flag_wb !== m_flag ||
              rf_rd !== m_rd || rf_wdata !== m_wd) begin
            n_fail++;
            $display("FAIL rnd%0d_load: we=%b ready=%b err=%b flag=%b rd=%0d wd=%h, required %b 0 0 %b %0d %h",
                     i, rf_wr_en, ex_ready, mem_err, flag_wb, rf_rd, rf_wdata, wr, m_flag, m_rd, m_wd);
          end
          tick();
        end else begin
          n_tests++;
          if (rf_wr_en !== 1'b0 || ex_ready !== 1'b1 || mem_err !== 1'b0 || flag_wb !== m_flag ||
              rf_rd !== m_rd || rf_wdata !== m_wd) begin
            n_fail++;
            $display("FAIL rnd%0d_store: rfwe=%b ready=%b err=%b flag=%b rd=%0d wd=%h, required 0 1 0 %b %0d %h",
                     i, rf_wr_en, ex_ready, mem_err, flag_wb, rf_rd, rf_wdata, m_flag, m_rd, m_wd);
          end
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_alu();
    test_x0();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
